// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART receiver and transmitter.
//   - UART_CLKS_PER_BIT : default clk cycles per serial bit
//   - uart_state_e      : receiver FSM state encoding (3 bits)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
//   Two-flop synchronizer for the asynchronous serial line. Both flops reset
//   to 1 so the line reads as idle straight out of reset.
//   Ports:
//     clk  in  sole clock
//     rst  in  synchronous, active-high reset
//     d_i  in  asynchronous input
//     q_o  out synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 serial receiver. The line is synchronized, the start bit is confirmed
//   at its midpoint, and every following bit is sampled one bit time later,
//   i.e. in the middle of each bit. Good bytes appear on data_out with a
//   one-cycle data_valid pulse; a low stop bit gives a one-cycle frame_err
//   pulse and the byte is dropped.
//   Ports:
//     clk        in   sole clock
//     rst        in   synchronous, active-high reset
//     i_bit      in   asynchronous serial line, idles high
//     data_out   out  last good byte, held until the next good frame
//     data_valid out  1-cycle pulse, data_out updated this cycle
//     frame_err  out  1-cycle pulse, stop bit sampled low
//     busy       out  high in every state except IDLE
//     state_dbg  out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_bit,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic rx_s;

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (i_bit),
        .q_o (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic                 valid_q, valid_d;
    logic                 err_q,   err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            // Re-check the line half a bit in; a high line here was a glitch.
            START: begin
                if (cnt_q == HALF_M1) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DATA: begin
                if (cnt_q == BIT_M1) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Decide at mid-stop and return to IDLE at once, so a start bit
            // directly after the stop bit is caught.
            STOP: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // A held-low line (break) must not be parsed as further frames.
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != IDLE);
    assign state_dbg  = state_q;

endmodule
